mult_seq_param: RTL

//  Parametrised multi-cycle integer multiplier: FSM, operand registers and accumulator in one block.

---
 rtl/mult_seq_param.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/mult_seq_param.sv
// mult_seq_param
//   Parametrised multi-cycle integer multiplier. The operands are split into
//   A_CHUNK-bit pieces of a and B_CHUNK-bit pieces of b. One partial product
//   is added per cycle into a P_W-bit accumulator, so an operation takes
//   N = (A_W/A_CHUNK)*(B_W/B_CHUNK) compute cycles. Only one operation is in
//   flight at a time, and the handshake is start/ready/done.
//
//   Optional build macro: MULT_SIGNED_EN
//     Defined   - adds the signed_mode input. When signed_mode is 1, the
//                 operands are two's complement and the product is the signed
//                 P_W result.
//     Undefined - unsigned multiply only; no signed_mode port.
//
// Ports
//   clk          in   1            clock, rising edge
//   reset        in   1            asynchronous, active-high
//   start        in   1            request, honoured only while ready=1
//   a            in   A_W          multiplicand, captured on accepted start
//   b            in   B_W          multiplier, captured on accepted start
//   signed_mode  in   1            (MULT_SIGNED_EN only) captured on accepted start
//   ready        out  1            can accept start (IDLE or DONE)
//   busy         out  1            computing (CALC)
//   done         out  1            one-cycle pulse, product is final
//   product      out  A_W+B_W      accumulator; final value held until next start
//   step         out  clog2(N)+1   index of the partial product being added
module mult_seq_param #(
  parameter int A_W     = 32,
  parameter int B_W     = 32,
  parameter int A_CHUNK = 8,
  parameter int B_CHUNK = 16,
  localparam int NA     = A_W / A_CHUNK,
  localparam int NB     = B_W / B_CHUNK,
  localparam int N      = NA * NB,
  localparam int P_W    = A_W + B_W,
  localparam int STEP_W = $clog2(N) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [A_W-1:0]    a,
  input  logic [B_W-1:0]    b,
`ifdef MULT_SIGNED_EN
  input  logic              signed_mode,
`endif
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [P_W-1:0]    product,
  output logic [STEP_W-1:0] step
);

  // Chunk widths must tile the operands exactly.
  if (A_W % A_CHUNK != 0) begin : g_bad_a_chunk
    $error("mult_seq_param: A_W must be a multiple of A_CHUNK");
  end
  if (B_W % B_CHUNK != 0) begin : g_bad_b_chunk
    $error("mult_seq_param: B_W must be a multiple of B_CHUNK");
  end

  localparam int AI_W = (NA > 1) ? $clog2(NA) : 1;
  localparam int BJ_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [31:0] A_CHUNK_U = A_CHUNK;
  localparam logic [31:0] B_CHUNK_U = B_CHUNK;

`ifdef MULT_SIGNED_EN
  // Each chunk gets one extra bit so the top chunks can carry their sign.
  localparam int PP_W  = A_CHUNK + B_CHUNK + 2;
  localparam int EXT_W = (PP_W > P_W) ? PP_W : P_W;
`else
  localparam int PP_W  = A_CHUNK + B_CHUNK;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [A_W-1:0]  a_r;
  logic [B_W-1:0]  b_r;
  logic [AI_W-1:0] ai;       // a-chunk index (inner loop)
  logic [BJ_W-1:0] bj;       // b-chunk index (outer loop)
  logic            accept;
  logic            last;
`ifdef MULT_SIGNED_EN
  logic            sm_r;
`endif

  logic [A_CHUNK-1:0] a_chunk;
  logic [B_CHUNK-1:0] b_chunk;
  logic [31:0]        shamt;
  logic [P_W-1:0]     pp;
  logic [P_W-1:0]     pp_sh;

`ifdef MULT_SIGNED_EN
  // Multiply two chunks. A chunk is treated as signed only when its flag is set
  // (top chunk of a signed operand). The result is sign-extended, or truncated,
  // to P_W. Truncation is harmless because the accumulator is modulo 2^P_W.
  function automatic logic [P_W-1:0] partial_product(
    input logic [A_CHUNK-1:0] ac,
    input logic [B_CHUNK-1:0] bc,
    input logic               a_sgn,
    input logic               b_sgn
  );
    logic signed [A_CHUNK:0]  ax;
    logic signed [B_CHUNK:0]  bx;
    logic signed [PP_W-1:0]   prod;
    logic signed [EXT_W-1:0]  ext;
    ax   = {a_sgn & ac[A_CHUNK-1], ac};
    bx   = {b_sgn & bc[B_CHUNK-1], bc};
    prod = ax * bx;
    ext  = prod;
    return ext[P_W-1:0];
  endfunction
`else
  // Unsigned chunk product, zero-extended to P_W.
  function automatic logic [P_W-1:0] partial_product(
    input logic [A_CHUNK-1:0] ac,
    input logic [B_CHUNK-1:0] bc
  );
    logic [PP_W-1:0] prod;
    prod = {{B_CHUNK{1'b0}}, ac} * {{A_CHUNK{1'b0}}, bc};
    return P_W'(prod);
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Control: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign last = (step == STEP_W'(N - 1));

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        ready  = 1'b1;
        accept = start;
        if (start) state_nxt = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        ready  = 1'b1;
        done   = 1'b1;
        accept = start;
        state_nxt = start ? CALC : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Partial product for the current (ai, bj) pair
  // ---------------------------------------------------------------------------
  always_comb begin
    a_chunk = A_CHUNK'(a_r >> (32'(ai) * A_CHUNK_U));
    b_chunk = B_CHUNK'(b_r >> (32'(bj) * B_CHUNK_U));
    shamt   = 32'(ai) * A_CHUNK_U + 32'(bj) * B_CHUNK_U;
`ifdef MULT_SIGNED_EN
    pp      = partial_product(a_chunk, b_chunk,
                              sm_r && (ai == AI_W'(NA - 1)),
                              sm_r && (bj == BJ_W'(NB - 1)));
`else
    pp      = partial_product(a_chunk, b_chunk);
`endif
    pp_sh   = pp << shamt;
  end

  // ---------------------------------------------------------------------------
  // Operand registers, accumulator and step counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_r     <= '0;
      b_r     <= '0;
      product <= '0;
      step    <= '0;
      ai      <= '0;
      bj      <= '0;
`ifdef MULT_SIGNED_EN
      sm_r    <= 1'b0;
`endif
    end else if (accept) begin
      a_r     <= a;
      b_r     <= b;
      product <= '0;
      step    <= '0;
      ai      <= '0;
      bj      <= '0;
`ifdef MULT_SIGNED_EN
      sm_r    <= signed_mode;
`endif
    end else if (busy) begin
      product <= product + pp_sh;
      // On the last step the indices are left alone, so step stays at N-1
      // until the next accepted start.
      if (!last) begin
        step <= step + STEP_W'(1);
        if (ai == AI_W'(NA - 1)) begin
          ai <= '0;
          bj <= bj + BJ_W'(1);
        end else begin
          ai <= ai + AI_W'(1);
        end
      end
    end
  end

endmodule
